// File: rtl/fetch_defs.sv
// Shared widths and constants for the instruction fetch front end.
// Slot layout is common to the queue storage and the fetch control.
package fetch_defs;

    localparam int          XLEN             = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DISCARD_W        = 8;

    typedef struct packed {
        logic            filled;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } slot_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_slot_array.sv
// In-order slot store: a slot is reserved at grant, filled at response, freed at pop.
// Zero-latency head read; no backpressure of its own, the caller checks alloc_cnt_o.
module fetch_slot_array
    import fetch_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   alloc_i,
    input  logic [XLEN-1:0]        alloc_pc_i,
    input  logic                   fill_i,
    input  logic [XLEN-1:0]        fill_instr_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] alloc_cnt_o,
    output logic [$clog2(DEPTH):0] pend_cnt_o,
    output logic                   head_filled_o,
    output logic [XLEN-1:0]        head_instr_o,
    output logic [XLEN-1:0]        head_pc_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    slot_t          slots [DEPTH];
    logic [PW-1:0]  alloc_ptr;
    logic [PW-1:0]  fill_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  alloc_cnt;
    logic [CW-1:0]  pend_cnt;

    // alloc, fill and pop always target distinct slots, so their writes never collide
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
        end else begin
            if (alloc_i) begin
                slots[alloc_ptr].pc     <= alloc_pc_i;
                slots[alloc_ptr].filled <= 1'b0;
                alloc_ptr               <= alloc_ptr + PW'(1);
            end
            if (fill_i) begin
                slots[fill_ptr].instr  <= fill_instr_i;
                slots[fill_ptr].filled <= 1'b1;
                fill_ptr               <= fill_ptr + PW'(1);
            end
            if (pop_i) begin
                slots[rd_ptr].filled <= 1'b0;
                rd_ptr               <= rd_ptr + PW'(1);
            end
            alloc_cnt <= alloc_cnt + CW'(alloc_i) - CW'(pop_i);
            pend_cnt  <= pend_cnt + CW'(alloc_i) - CW'(fill_i);
        end
    end

    assign alloc_cnt_o   = alloc_cnt;
    assign pend_cnt_o    = pend_cnt;
    assign head_filled_o = slots[rd_ptr].filled;
    assign head_instr_o  = slots[rd_ptr].instr;
    assign head_pc_o     = slots[rd_ptr].pc;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC owner, imem requester and in-order instruction queue; grant-to-valid is L+1 cycles.
// Requests stop when every slot is reserved; redirect flushes and drops in-flight responses.
module instr_fetch_queue
    import fetch_defs::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]      fetch_pc;
    logic [DISCARD_W-1:0] discard_cnt;
    logic [CW-1:0]        alloc_cnt;
    logic [CW-1:0]        pend_cnt;
    logic                 head_filled;
    logic                 grant;
    logic                 dropping;
    logic                 fill;
    logic                 pop;

    assign imem_req_o    = (alloc_cnt < CW'(DEPTH)) & ~redirect_i & ~rst_i;
    assign imem_addr_o   = fetch_pc;
    assign grant         = imem_req_o & imem_gnt_i;
    assign dropping      = (discard_cnt != '0);
    assign fill          = imem_rvalid_i & ~dropping & ~redirect_i;
    assign instr_valid_o = head_filled & (alloc_cnt != '0);
    assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;

    fetch_slot_array #(
        .DEPTH (DEPTH)
    ) u_slots (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (redirect_i),
        .alloc_i       (grant),
        .alloc_pc_i    (fetch_pc),
        .fill_i        (fill),
        .fill_instr_i  (imem_rdata_i),
        .pop_i         (pop),
        .alloc_cnt_o   (alloc_cnt),
        .pend_cnt_o    (pend_cnt),
        .head_filled_o (head_filled),
        .head_instr_o  (instr_o),
        .head_pc_o     (instr_pc_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= align_pc(redirect_pc_i);
        end else if (grant) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    // Every in-flight response is either still owed to a live slot or counted here;
    // on redirect the response arriving this cycle settles one of the orphaned slots.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            discard_cnt <= '0;
        end else if (redirect_i) begin
            discard_cnt <= discard_cnt + DISCARD_W'(pend_cnt) - DISCARD_W'(imem_rvalid_i);
        end else if (imem_rvalid_i && dropping) begin
            discard_cnt <= discard_cnt - DISCARD_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed vector table for streaming/redirect/stall timing, then model-driven corner sequences.
module tb_instr_fetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;

    always #5 clk_i = ~clk_i;

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    // Memory side is either driven from the vector table or from the latency model
    logic        use_model = 1'b0;
    logic        t_gnt = 1'b0, t_rvalid = 1'b0;
    logic [31:0] t_rdata = '0;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    assign imem_gnt_i    = use_model ? m_gnt    : t_gnt;
    assign imem_rvalid_i = use_model ? m_rvalid : t_rvalid;
    assign imem_rdata_i  = use_model ? m_rdata  : t_rdata;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t        rq[$];
    rsp_t        rq_dummy;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_v, due_v;
    int          lat_min = 1, lat_max = 1;
    int          gnt_pct = 100;
    int          gnt_count = 0;
    logic [31:0] last_gnt_addr = '0;

    always @(posedge clk_i) begin
        cyc++;
        #1;
        if (use_model) begin
            m_gnt = ($urandom_range(99) < gnt_pct);
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                m_rvalid = 1'b1;
                m_rdata  = rq[0].addr ^ 32'hA5A5_0000;
            end else begin
                m_rvalid = 1'b0;
                m_rdata  = '0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            rq.delete();
            last_due = 0;
        end else if (use_model) begin
            if (m_rvalid && rq.size() > 0) rq_dummy = rq.pop_front();
            if (imem_req_o && imem_gnt_i) begin
                lat_v = $urandom_range(lat_max, lat_min);
                due_v = cyc + lat_v;
                if (due_v <= last_due) due_v = last_due + 1;
                last_due = due_v;
                rq.push_back('{addr: imem_addr_o, due: due_v});
                gnt_count++;
                last_gnt_addr = imem_addr_o;
            end
        end
    end

    // ---------------- consumer scoreboard ----------------
    logic        sb_en = 1'b0;
    logic [31:0] exp_pc = '0;
    int          pop_count = 0;

    always @(negedge clk_i) begin
        if (sb_en && !rst_i && !redirect_i && instr_valid_o && instr_ready_i) begin
            check("pop_pc", instr_pc_o, exp_pc);
            check("pop_instr", instr_o, exp_pc ^ 32'hA5A5_0000);
            exp_pc = exp_pc + 32'd4;
            pop_count++;
        end
    end

    task automatic wait_pops(input int n, input int budget, input string name);
        for (int i = 0; i < budget && pop_count < n; i++) step();
        check(name, 32'(pop_count >= n), 32'd1);
    endtask

    task automatic reset_model_run();
        rst_i = 1'b1;
        redirect_i = 1'b0;
        repeat (2) step();
        gnt_count = 0;
        pop_count = 0;
        exp_pc    = 32'h0;
        rst_i     = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                                input logic rdr, input logic [31:0] rpc, input logic rdy,
                                input logic req, input logic [31:0] addr, input logic vld,
                                input logic [31:0] ins, input logic [31:0] pc);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.redir = rdr; v.rpc = rpc; v.ready = rdy;
        v.req = req; v.addr = addr; v.vld = vld; v.instr = ins; v.pc = pc;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        //          gnt rv rdata          rdr rpc           rdy | req addr          vld instr          pc
        tbl[0]  = mk(1, 0, 32'h0,          0, 32'h0,         1,    1, 32'h0000_0000, 0, 32'h0,          32'h0);
        tbl[1]  = mk(1, 1, 32'hA5A5_0000,  0, 32'h0,         1,    1, 32'h0000_0004, 0, 32'h0,          32'h0);
        tbl[2]  = mk(1, 1, 32'hA5A5_0004,  0, 32'h0,         1,    1, 32'h0000_0008, 1, 32'hA5A5_0000,  32'h000);
        tbl[3]  = mk(1, 1, 32'hA5A5_0008,  0, 32'h0,         1,    1, 32'h0000_000C, 1, 32'hA5A5_0004,  32'h004);
        tbl[4]  = mk(1, 1, 32'hA5A5_000C,  0, 32'h0,         1,    1, 32'h0000_0010, 1, 32'hA5A5_0008,  32'h008);
        tbl[5]  = mk(1, 1, 32'hA5A5_0010,  1, 32'h0000_0203, 1,    0, 32'h0000_0014, 1, 32'hA5A5_000C,  32'h00C);
        tbl[6]  = mk(1, 0, 32'h0,          0, 32'h0,         1,    1, 32'h0000_0200, 0, 32'h0,          32'h0);
        tbl[7]  = mk(1, 1, 32'hA5A5_0200,  0, 32'h0,         1,    1, 32'h0000_0204, 0, 32'h0,          32'h0);
        tbl[8]  = mk(1, 1, 32'hA5A5_0204,  0, 32'h0,         1,    1, 32'h0000_0208, 1, 32'hA5A5_0200,  32'h200);
        tbl[9]  = mk(0, 1, 32'hA5A5_0208,  0, 32'h0,         0,    1, 32'h0000_020C, 1, 32'hA5A5_0204,  32'h204);
        tbl[10] = mk(1, 0, 32'h0,          0, 32'h0,         0,    1, 32'h0000_020C, 1, 32'hA5A5_0204,  32'h204);
        tbl[11] = mk(0, 1, 32'hA5A5_020C,  0, 32'h0,         1,    1, 32'h0000_0210, 1, 32'hA5A5_0204,  32'h204);
        tbl[12] = mk(0, 0, 32'h0,          0, 32'h0,         1,    1, 32'h0000_0210, 1, 32'hA5A5_0208,  32'h208);
        tbl[13] = mk(0, 0, 32'h0,          0, 32'h0,         1,    1, 32'h0000_0210, 1, 32'hA5A5_020C,  32'h20C);
        tbl[14] = mk(0, 0, 32'h0,          0, 32'h0,         1,    1, 32'h0000_0210, 0, 32'h0,          32'h0);

        // reset state
        #12;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", instr_pc_o, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);

        step();
        rst_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            t_gnt = tbl[i].gnt; t_rvalid = tbl[i].rvalid; t_rdata = tbl[i].rdata;
            redirect_i = tbl[i].redir; redirect_pc_i = tbl[i].rpc; instr_ready_i = tbl[i].ready;
            #3;
            check($sformatf("row%0d_req", i), 32'(imem_req_o), 32'(tbl[i].req));
            check($sformatf("row%0d_addr", i), imem_addr_o, tbl[i].addr);
            check($sformatf("row%0d_valid", i), 32'(instr_valid_o), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                check($sformatf("row%0d_instr", i), instr_o, tbl[i].instr);
                check($sformatf("row%0d_pc", i), instr_pc_o, tbl[i].pc);
            end
            step();
        end
        t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0; redirect_i = 1'b0; redirect_pc_i = '0;

        // stall: ready low fills all slots, then drains in order and fetch resumes at 0x10
        use_model = 1'b1; sb_en = 1'b1;
        gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready_i = 1'b0;
        reset_model_run();
        repeat (10) step();
        check("stall_grants", 32'(gnt_count), 32'd4);
        check("stall_req", 32'(imem_req_o), 32'd0);
        check("stall_valid", 32'(instr_valid_o), 32'd1);
        check("stall_head_pc", instr_pc_o, 32'h0);
        instr_ready_i = 1'b1;
        for (int i = 0; i < 10 && gnt_count < 5; i++) step();
        check("resume_addr", last_gnt_addr, 32'h10);
        wait_pops(8, 40, "drain_pops");

        // L=3 redirect with two responses outstanding
        lat_min = 3; lat_max = 3;
        reset_model_run();
        step();
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h100; exp_pc = 32'h100;
        #1;
        check("redir_outstanding", 32'(gnt_count), 32'd2);
        check("redir_req_low", 32'(imem_req_o), 32'd0);
        step();
        redirect_i = 1'b0; redirect_pc_i = '0;
        #1;
        check("post_redir_req", 32'(imem_req_o), 32'd1);
        check("post_redir_addr", imem_addr_o, 32'h100);
        check("post_redir_valid", 32'(instr_valid_o), 32'd0);
        wait_pops(2, 30, "redir_pops");

        // random grant and latency: order and data checked by the scoreboard
        gnt_pct = 50; lat_min = 1; lat_max = 5;
        reset_model_run();
        for (int i = 0; i < 300; i++) begin
            instr_ready_i = ($urandom_range(99) < 70);
            step();
        end
        check("random_progress", 32'(pop_count > 20), 32'd1);

        // asynchronous reset mid-burst
        gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready_i = 1'b1;
        reset_model_run();
        repeat (8) step();
        check("burst_valid", 32'(instr_valid_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_valid", 32'(instr_valid_o), 32'd0);
        check("async_req", 32'(imem_req_o), 32'd0);
        step();
        step();
        exp_pc = 32'h0; pop_count = 0;
        rst_i = 1'b0;
        #1;
        check("rerst_req", 32'(imem_req_o), 32'd1);
        check("rerst_addr", imem_addr_o, 32'h0);
        wait_pops(4, 20, "rerst_pops");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
